// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: scan-out fetches of packed RGB332 words always win,
// the host gets the remaining cycles through a REQ/ACK handshake.
module vram_arbiter #(
    parameter int H_START = 216,
    parameter int V_START = 27,
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int ADDR_W  = 17
) (
    input  logic              PIX_CLK,
    input  logic              RST,
    input  logic [9:0]        HC,
    input  logic [9:0]        VC,
    output logic [7:0]        PIX_DATA,
    output logic              VBLANK,
    output logic              MEM_CE,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [3:0]        MEM_BE,
    output logic [31:0]       MEM_WDATA,
    input  logic [31:0]       MEM_RDATA,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [31:0]       CPU_WDATA,
    input  logic [3:0]        CPU_BE,
    output logic              CPU_ACK,
    output logic [31:0]       CPU_RDATA
);

    localparam logic [10:0] HS = 11'(H_START);
    localparam logic [10:0] HA = 11'(H_ACT);
    localparam logic [10:0] VS = 11'(V_START);
    localparam logic [10:0] VA = 11'(V_ACT);

    logic [10:0]       vc_rel;
    logic [10:0]       slot_rel;
    logic [10:0]       vis_rel;
    logic [10:0]       copy_rel;
    logic              active_line;
    logic              slot;
    logic              visible;
    logic              copy;
    logic              grant;

    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              slot_q, slot_d;
    logic [31:0]       hold_q, hold_d;
    logic [31:0]       pix_q, pix_d;
    logic              ack_q, ack_d;
    logic              ack_rd_q, ack_rd_d;
    logic [31:0]       rdata_q, rdata_d;

    // Offsets are taken in 11 bits so that counters below the window wrap to large values.
    always_comb begin
        vc_rel      = {1'b0, VC} - VS;
        slot_rel    = {1'b0, HC} + 11'd4 - HS;
        vis_rel     = {1'b0, HC} - HS;
        copy_rel    = {1'b0, HC} + 11'd1 - HS;
        active_line = (vc_rel < VA);
        slot        = !RST && active_line && (slot_rel < HA) && (slot_rel[1:0] == 2'd0);
        visible     = active_line && (vis_rel < HA);
        copy        = active_line && (copy_rel < HA) && (copy_rel[1:0] == 2'd0);
        grant       = !RST && !slot && CPU_REQ && !ack_q;
    end

    // Next-state for the fetch pipeline and the host handshake.
    always_comb begin
        if (!active_line) begin
            fetch_addr_d = '0;
        end else if (slot) begin
            fetch_addr_d = fetch_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            fetch_addr_d = fetch_addr_q;
        end
        slot_d   = slot;
        hold_d   = slot_q ? MEM_RDATA : hold_q;
        pix_d    = copy ? hold_q : pix_q;
        ack_d    = grant;
        ack_rd_d = grant && !CPU_WE;
        rdata_d  = (ack_q && ack_rd_q) ? MEM_RDATA : rdata_q;
    end

    // State registers.
    always_ff @(posedge PIX_CLK or posedge RST) begin
        if (RST) begin
            fetch_addr_q <= '0;
            slot_q       <= 1'b0;
            hold_q       <= 32'd0;
            pix_q        <= 32'd0;
            ack_q        <= 1'b0;
            ack_rd_q     <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            slot_q       <= slot_d;
            hold_q       <= hold_d;
            pix_q        <= pix_d;
            ack_q        <= ack_d;
            ack_rd_q     <= ack_rd_d;
            rdata_q      <= rdata_d;
        end
    end

    // RAM port mux: display slot first, then host grant, otherwise idle.
    always_comb begin
        MEM_CE    = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_BE    = 4'd0;
        MEM_WDATA = 32'd0;
        if (slot) begin
            MEM_CE   = 1'b1;
            MEM_ADDR = fetch_addr_q;
        end else if (grant) begin
            MEM_CE    = 1'b1;
            MEM_WE    = CPU_WE;
            MEM_ADDR  = CPU_ADDR;
            MEM_BE    = CPU_BE;
            MEM_WDATA = CPU_WDATA;
        end else begin
            MEM_CE = 1'b0;
        end
    end

    // Pixel select, blanking and host read data; read data is passed through during its ACK.
    always_comb begin
        PIX_DATA = 8'd0;
        if (visible && !RST) begin
            case (vis_rel[1:0])
                2'd0:    PIX_DATA = pix_q[7:0];
                2'd1:    PIX_DATA = pix_q[15:8];
                2'd2:    PIX_DATA = pix_q[23:16];
                2'd3:    PIX_DATA = pix_q[31:24];
                default: PIX_DATA = 8'd0;
            endcase
        end else begin
            PIX_DATA = 8'd0;
        end
        VBLANK    = !RST && !active_line;
        CPU_ACK   = ack_q;
        CPU_RDATA = (ack_q && ack_rd_q) ? MEM_RDATA : rdata_q;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM attached to the MEM_* port.
module tb_vram_arbiter;

    logic        PIX_CLK = 1'b0;
    logic        RST;
    logic [9:0]  HC, VC;
    logic [7:0]  PIX_DATA;
    logic        VBLANK, MEM_CE, MEM_WE;
    logic [16:0] MEM_ADDR;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA = 32'd0;
    logic        CPU_REQ, CPU_WE;
    logic [16:0] CPU_ADDR;
    logic [31:0] CPU_WDATA;
    logic [3:0]  CPU_BE;
    logic        CPU_ACK;
    logic [31:0] CPU_RDATA;

    int n_assert = 0;
    int n_fail   = 0;

    vram_arbiter dut (
        .PIX_CLK(PIX_CLK), .RST(RST), .HC(HC), .VC(VC),
        .PIX_DATA(PIX_DATA), .VBLANK(VBLANK),
        .MEM_CE(MEM_CE), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_BE(CPU_BE), .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA)
    );

    always #5 PIX_CLK = ~PIX_CLK;

    // Sparse RAM: unwritten words read back a fixed per-address pattern.
    logic [31:0] mem [int];
    logic [31:0] wtmp;

    function automatic logic [31:0] init_pat(input int a);
        case (a)
            0:       return 32'h44332211;
            1:       return 32'h88776655;
            5:       return 32'h11223344;
            default: return {16'(a), ~16'(a)};
        endcase
    endfunction

    function automatic logic [31:0] rd_mem(input int a);
        if (mem.exists(a)) return mem[a];
        return init_pat(a);
    endfunction

    always @(posedge PIX_CLK) begin
        if (MEM_CE) begin
            if (MEM_WE) begin
                wtmp = rd_mem(int'(MEM_ADDR));
                for (int b = 0; b < 4; b++)
                    if (MEM_BE[b]) wtmp[b*8 +: 8] = MEM_WDATA[b*8 +: 8];
                mem[int'(MEM_ADDR)] = wtmp;
            end else begin
                MEM_RDATA <= rd_mem(int'(MEM_ADDR));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int hc, input int vc);
        HC = 10'(hc);
        VC = 10'(vc);
        #1;
    endtask

    task automatic adv();
        @(posedge PIX_CLK);
        #1;
    endtask

    initial begin
        int  last_ack;
        logic prev_grant, slot_e, grant_e;
        logic [7:0] eb;

        RST = 1'b1; HC = 10'd0; VC = 10'd0;
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 17'd3; CPU_WDATA = 32'd0; CPU_BE = 4'd0;
        #2;
        chk("rst_ce", 32'(MEM_CE), 32'd0);
        chk("rst_vblank", 32'(VBLANK), 32'd0);
        chk("rst_ack", 32'(CPU_ACK), 32'd0);
        chk("rst_pix", 32'(PIX_DATA), 32'd0);
        chk("rst_rdata", CPU_RDATA, 32'd0);
        adv();
        RST = 1'b0; CPU_REQ = 1'b0;
        #1;
        chk("vblank_after_rst", 32'(VBLANK), 32'd1);

        // Host read granted, then reset pulsed across the edge: no ACK may follow.
        adv();
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 17'd3;
        put(0, 0);
        chk("grant_before_rst", {MEM_CE, MEM_WE, 13'd0, MEM_ADDR}, {1'b1, 1'b0, 13'd0, 17'd3});
        RST = 1'b1;
        #1;
        chk("rst_mid_ce", 32'(MEM_CE), 32'd0);
        adv();
        chk("rst_mid_ack", 32'(CPU_ACK), 32'd0);
        RST = 1'b0; CPU_REQ = 1'b0;
        #1;
        chk("post_rst_ack0", 32'(CPU_ACK), 32'd0);
        adv();
        chk("post_rst_ack1", 32'(CPU_ACK), 32'd0);

        // First visible line: fetch slots and pixel byte order.
        for (int hc = 200; hc <= 860; hc++) begin
            put(hc, 27);
            if (hc == 212) chk("slot212", {MEM_CE, MEM_WE, MEM_BE, 9'd0, MEM_ADDR}, {1'b1, 1'b0, 4'd0, 9'd0, 17'd0});
            if (hc == 213) chk("idle213", 32'(MEM_CE), 32'd0);
            if (hc == 216) chk("slot216", {MEM_CE, 14'd0, MEM_ADDR}, {1'b1, 14'd0, 17'd1});
            if (hc == 215) chk("pix_pre", 32'(PIX_DATA), 32'd0);
            if (hc >= 216 && hc <= 223) begin
                eb = 8'(8'h11 * (hc - 215));
                chk($sformatf("pix%0d", hc), 32'(PIX_DATA), 32'(eb));
            end
            if (hc == 848) chk("slot_last_l0", {MEM_CE, 14'd0, MEM_ADDR}, {1'b1, 14'd0, 17'd159});
            if (hc == 856) chk("pix_post", 32'(PIX_DATA), 32'd0);
            adv();
        end

        // Second line: host write colliding with a slot, then a continuously held host read.
        prev_grant = 1'b0;
        last_ack = -10;
        for (int hc = 200; hc <= 860; hc++) begin
            if (hc == 212) begin
                CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 17'd5;
                CPU_WDATA = 32'hDEADBEEF; CPU_BE = 4'b0101;
            end
            if (hc == 230) begin
                CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 17'd5; CPU_BE = 4'd0;
            end
            if (hc == 261) CPU_REQ = 1'b0;
            put(hc, 28);
            if (hc == 212) chk("wr_slot_wins", {MEM_CE, MEM_WE, 13'd0, MEM_ADDR}, {1'b1, 1'b0, 13'd0, 17'd160});
            if (hc == 213) begin
                chk("wr_grant", {MEM_CE, MEM_WE, MEM_BE, 9'd0, MEM_ADDR}, {1'b1, 1'b1, 4'b0101, 9'd0, 17'd5});
                chk("wr_wdata", MEM_WDATA, 32'hDEADBEEF);
            end
            if (hc == 214) begin
                chk("wr_ack", 32'(CPU_ACK), 32'd1);
                chk("wr_no_regrant", 32'(MEM_CE), 32'd0);
                CPU_REQ = 1'b0;
            end
            if (hc == 215) begin
                chk("wr_ack_pulse", 32'(CPU_ACK), 32'd0);
                chk("wr_bytes", rd_mem(5), 32'h11AD33EF);
            end
            if (hc == 216) chk("pix_row1", 32'(PIX_DATA), 32'h5F);
            if (hc >= 230 && hc <= 260) begin
                slot_e  = ((hc - 212) % 4) == 0;
                grant_e = !slot_e && !prev_grant;
                chk($sformatf("rd_ce%0d", hc), 32'(MEM_CE), 32'(slot_e || grant_e));
                chk($sformatf("rd_ack%0d", hc), 32'(CPU_ACK), 32'(prev_grant));
                if (slot_e) chk($sformatf("rd_slot%0d", hc), {MEM_WE, 14'd0, MEM_ADDR}, 32'(160 + (hc - 212) / 4));
                if (grant_e) chk($sformatf("rd_gnt%0d", hc), {MEM_WE, 14'd0, MEM_ADDR}, 32'd5);
                if (CPU_ACK) begin
                    chk($sformatf("rd_space%0d", hc), 32'(hc - last_ack >= 2), 32'd1);
                    chk($sformatf("rd_data%0d", hc), CPU_RDATA, 32'h11AD33EF);
                    last_ack = hc;
                end
                prev_grant = grant_e;
            end
            if (hc == 270) chk("rd_held", CPU_RDATA, 32'h11AD33EF);
            adv();
        end

        // Remaining lines, visiting only the fetch slots.
        for (int vc = 29; vc <= 506; vc++) begin
            for (int k = 0; k < 160; k++) begin
                put(212 + 4 * k, vc);
                if (vc == 29 && k == 0) chk("row2_first", {MEM_CE, 14'd0, MEM_ADDR}, {1'b1, 14'd0, 17'd320});
                if (vc == 506 && k == 159) chk("frame_last", {MEM_CE, 14'd0, MEM_ADDR}, {1'b1, 14'd0, 17'd76799});
                adv();
            end
        end

        // Vertical blank: no display fetches, host served every other cycle.
        put(212, 507);
        chk("vb_flag", 32'(VBLANK), 32'd1);
        chk("vb_no_slot", 32'(MEM_CE), 32'd0);
        adv();
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 17'd7;
        for (int i = 0; i < 10; i++) begin
            put(212 + i, 507);
            chk($sformatf("vb_ce%0d", i), 32'(MEM_CE), 32'(i % 2 == 0));
            chk($sformatf("vb_ack%0d", i), 32'(CPU_ACK), 32'(i % 2 == 1));
            if (i % 2 == 0) chk($sformatf("vb_addr%0d", i), {MEM_WE, 14'd0, MEM_ADDR}, 32'd7);
            else chk($sformatf("vb_rdata%0d", i), CPU_RDATA, 32'h0007FFF8);
            adv();
        end
        CPU_REQ = 1'b0;

        // Next frame restarts fetching at word 0.
        put(212, 27);
        chk("frame2_first", {MEM_CE, 14'd0, MEM_ADDR}, {1'b1, 14'd0, 17'd0});
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
